// File: rtl/alu_issue.sv
// Issue stage: decodes Beta ALU instructions, captures operands and presents one
// registered {a, b, fn, rc} bundle downstream, holding MUL/DIV for a fixed wait.
module alu_issue #(
  parameter int MUL_WAIT = 2,
  parameter int DIV_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  ra_addr,
  output logic [4:0]  rb_addr,
  input  logic [31:0] ra_data,
  input  logic [31:0] rb_data,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  output logic [4:0]  rc,
  output logic        illegal,
  output logic [1:0]  dbg_state_o
);

  // ALU function codes, matching the alu_* values in risc_constants.vh.
  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [5:0] ALU_SUB   = 6'h01;
  localparam logic [5:0] ALU_MUL   = 6'h02;
  localparam logic [5:0] ALU_DIV   = 6'h03;
  localparam logic [5:0] ALU_CMPEQ = 6'h33;
  localparam logic [5:0] ALU_CMPLT = 6'h35;
  localparam logic [5:0] ALU_CMPLE = 6'h37;
  localparam logic [5:0] ALU_AND   = 6'h18;
  localparam logic [5:0] ALU_OR    = 6'h1E;
  localparam logic [5:0] ALU_XOR   = 6'h16;
  localparam logic [5:0] ALU_XNOR  = 6'h19;
  localparam logic [5:0] ALU_SHL   = 6'h20;
  localparam logic [5:0] ALU_SHR   = 6'h21;
  localparam logic [5:0] ALU_SRA   = 6'h23;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  localparam int MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
  localparam int CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_WAIT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_WAIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic [31:0]   a_q, b_q;
  logic [5:0]    fn_q;
  logic [4:0]    rc_q;

  logic [5:0]    op;
  logic [5:0]    fn_dec;
  logic          legal, is_mul, is_div;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   op_a, op_b;
  logic          accept, load;

  assign op      = instr[31:26];
  assign ra_addr = instr[20:16];
  assign rb_addr = instr[15:11];

  always_comb begin
    legal  = op[5];
    fn_dec = ALU_ADD;
    case (op[3:0])
      4'h0:    fn_dec = ALU_ADD;
      4'h1:    fn_dec = ALU_SUB;
      4'h2:    fn_dec = ALU_MUL;
      4'h3:    fn_dec = ALU_DIV;
      4'h4:    fn_dec = ALU_CMPEQ;
      4'h5:    fn_dec = ALU_CMPLT;
      4'h6:    fn_dec = ALU_CMPLE;
      4'h8:    fn_dec = ALU_AND;
      4'h9:    fn_dec = ALU_OR;
      4'hA:    fn_dec = ALU_XOR;
      4'hB:    fn_dec = ALU_XNOR;
      4'hC:    fn_dec = ALU_SHL;
      4'hD:    fn_dec = ALU_SHR;
      4'hE:    fn_dec = ALU_SRA;
      default: legal  = 1'b0;
    endcase
  end

  assign is_mul   = legal && (op[3:0] == 4'h2);
  assign is_div   = legal && (op[3:0] == 4'h3);
  assign wait_cnt = is_mul ? MUL_CNT : DIV_CNT;

  // R31 reads as zero; literal forms replace rb with the sign-extended literal.
  assign op_a = (instr[20:16] == 5'd31) ? 32'd0 : ra_data;
  assign op_b = op[4] ? {{16{instr[15]}}, instr[15:0]}
                      : ((instr[15:11] == 5'd31) ? 32'd0 : rb_data);

  assign instr_ready = (state_q == S_IDLE) || ((state_q == S_VALID) && issue_ready);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_VALID;
      end
      S_VALID: if (issue_ready) state_d = S_IDLE;
      default: ;
    endcase
    // Acceptance can only happen in IDLE or on a VALID handshake, so it overrides.
    if (accept) begin
      if (!legal) begin
        state_d   = S_IDLE;
        illegal_d = 1'b1;
      end else if ((is_mul || is_div) && (wait_cnt != '0)) begin
        state_d = S_WAIT;
        cnt_d   = wait_cnt;
        load    = 1'b1;
      end else begin
        state_d = S_VALID;
        load    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      fn_q      <= 6'd0;
      rc_q      <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      if (load) begin
        a_q  <= op_a;
        b_q  <= op_b;
        fn_q <= fn_dec;
        rc_q <= instr[25:21];
      end
    end
  end

  assign issue_valid = (state_q == S_VALID);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_fn      = fn_q;
  assign rc          = rc_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode, R31/literal operands, MUL/DIV wait,
// backpressure streaming, illegal opcodes and reset during WAIT.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_fn;
  logic [4:0]  rc;
  logic        illegal;
  logic [1:0]  dbg_state;

  localparam logic [5:0] FN_ADD   = 6'h00;
  localparam logic [5:0] FN_SUB   = 6'h01;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_DIV   = 6'h03;
  localparam logic [5:0] FN_CMPLE = 6'h37;
  localparam logic [5:0] FN_AND   = 6'h18;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_q[$];

  alu_issue #(.MUL_WAIT(2), .DIV_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .rc(rc),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rform(input logic [5:0] op, input logic [4:0] rcf,
                                        input logic [4:0] raf, input logic [4:0] rbf);
    return {op, rcf, raf, rbf, 11'd0};
  endfunction

  function automatic logic [31:0] lform(input logic [5:0] op, input logic [4:0] rcf,
                                        input logic [4:0] raf, input logic [15:0] lit);
    return {op, rcf, raf, lit};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] fn, input logic [4:0] rcx);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, "_a"}, alu_a, a);
    chk({tag, "_b"}, alu_b, b);
    chk({tag, "_fn"}, 32'(alu_fn), 32'(fn));
    chk({tag, "_rc"}, 32'(rc), 32'(rcx));
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    instr_valid = 1'b1;
    instr       = w;
    ra_data     = a;
    rb_data     = b;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    issue_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    issue_ready = 1'b0;
    chk({tag, "_drained"}, 32'(issue_valid), 32'd0);
  endtask

  initial begin
    logic [63:0] e;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    ra_data     = 32'd0;
    rb_data     = 32'd0;
    issue_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_fn", 32'(alu_fn), 32'd0);
    chk("rst_rc", 32'(rc), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);

    instr = 32'h80611000;
    #1;
    chk("ra_addr", 32'(ra_addr), 32'd1);
    chk("rb_addr", 32'(rb_addr), 32'd2);
    @(negedge clk);

    send(32'h80611000, 32'd5, 32'd7);
    chk_bundle("add", 32'd5, 32'd7, FN_ADD, 5'd3);
    chk("add_ready_held", 32'(instr_ready), 32'd0);
    drain("add");

    send(32'hC041FFFC, 32'd10, 32'd0);
    chk_bundle("addc", 32'd10, 32'hFFFFFFFC, FN_ADD, 5'd2);
    drain("addc");

    send(rform(6'h20, 5'd4, 5'd31, 5'd2), 32'hDEADBEEF, 32'd3);
    chk_bundle("ra31", 32'd0, 32'd3, FN_ADD, 5'd4);
    drain("ra31");

    send(rform(6'h21, 5'd5, 5'd1, 5'd31), 32'd9, 32'h1234);
    chk_bundle("rb31", 32'd9, 32'd0, FN_SUB, 5'd5);
    drain("rb31");

    send(lform(6'h36, 5'd6, 5'd1, 16'h7FFF), 32'd20, 32'd55);
    chk_bundle("cmplec", 32'd20, 32'h00007FFF, FN_CMPLE, 5'd6);
    drain("cmplec");

    send(lform(6'h38, 5'd7, 5'd2, 16'h00F0), 32'hFF, 32'hAAAA);
    chk_bundle("andc", 32'hFF, 32'hF0, FN_AND, 5'd7);
    drain("andc");

    // MUL: wait of 2 -> valid 3 cycles after acceptance.
    send(rform(6'h22, 5'd8, 5'd1, 5'd2), 32'd6, 32'd7);
    chk("mul_w0_valid", 32'(issue_valid), 32'd0);
    chk("mul_w0_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("mul_w1_valid", 32'(issue_valid), 32'd0);
    @(negedge clk);
    chk_bundle("mul", 32'd6, 32'd7, FN_MUL, 5'd8);
    drain("mul");

    // DIV with an ADD waiting behind it.
    issue_ready = 1'b1;
    send(rform(6'h23, 5'd10, 5'd1, 5'd2), 32'd100, 32'd7);
    chk("div_state", 32'(dbg_state), 32'd1);
    instr_valid = 1'b1;
    instr       = rform(6'h20, 5'd11, 5'd1, 5'd2);
    ra_data     = 32'd1;
    rb_data     = 32'd2;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("div_wait%0d_valid", k), 32'(issue_valid), 32'd0);
      chk($sformatf("div_wait%0d_ready", k), 32'(instr_ready), 32'd0);
      @(negedge clk);
    end
    chk_bundle("div", 32'd100, 32'd7, FN_DIV, 5'd10);
    chk("div_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk_bundle("div_next", 32'd1, 32'd2, FN_ADD, 5'd11);
    @(negedge clk);
    chk("div_done_valid", 32'(issue_valid), 32'd0);
    issue_ready = 1'b0;

    // Backpressure then streaming of four ADDs.
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h100 + 32'(i), 32'(i)});
    send(rform(6'h20, 5'd12, 5'd1, 5'd2), 32'h100, 32'd0);
    instr_valid = 1'b1;
    instr       = rform(6'h20, 5'd13, 5'd1, 5'd2);
    ra_data     = 32'h101;
    rb_data     = 32'd1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(issue_valid), 32'd1);
      chk("bp_ready", 32'(instr_ready), 32'd0);
      chk("bp_a", alu_a, 32'h100);
      chk("bp_rc", 32'(rc), 32'd12);
      @(negedge clk);
    end
    issue_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("stream%0d_valid", i - 1), 32'(issue_valid), 32'd1);
      chk($sformatf("stream%0d_a", i - 1), alu_a, e[63:32]);
      chk($sformatf("stream%0d_b", i - 1), alu_b, e[31:0]);
      chk($sformatf("stream%0d_rc", i - 1), 32'(rc), 32'd11 + e[31:0] + 32'd1);
      if (i < 4) begin
        instr_valid = 1'b1;
        instr       = rform(6'h20, 5'(12 + i), 5'd1, 5'd2);
        ra_data     = 32'h100 + 32'(i);
        rb_data     = 32'(i);
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_end_valid", 32'(issue_valid), 32'd0);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);
    issue_ready = 1'b0;

    // Illegal opcodes.
    send(rform(6'h27, 5'd1, 5'd1, 5'd1), 32'd1, 32'd1);
    chk("ill27_pulse", 32'(illegal), 32'd1);
    chk("ill27_valid", 32'(issue_valid), 32'd0);
    chk("ill27_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("ill27_pulse_end", 32'(illegal), 32'd0);
    chk("ill27_no_issue", 32'(issue_valid), 32'd0);
    send(rform(6'h05, 5'd1, 5'd1, 5'd1), 32'd1, 32'd1);
    chk("ill05_pulse", 32'(illegal), 32'd1);
    @(negedge clk);
    chk("ill05_pulse_end", 32'(illegal), 32'd0);

    // Reset in the middle of a MUL wait.
    send(rform(6'h22, 5'd9, 5'd1, 5'd2), 32'd3, 32'd4);
    chk("mulrst_ready", 32'(instr_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mulrst_a", alu_a, 32'd0);
    chk("mulrst_b", alu_b, 32'd0);
    chk("mulrst_fn", 32'(alu_fn), 32'd0);
    chk("mulrst_rc", 32'(rc), 32'd0);
    chk("mulrst_valid", 32'(issue_valid), 32'd0);
    chk("mulrst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("mulrst_no_issue", 32'(issue_valid), 32'd0);
      chk("mulrst_idle_ready", 32'(instr_ready), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage between instruction fetch and the datapath ALU. It accepts 32-bit Beta-format ALU instructions over a valid/ready handshake and drives the register-file read addresses. It captures operands, maps the opcode to the ALU function code from `risc_constants.vh`, and presents one registered `{a, b, fn, rc}` bundle downstream over a second valid/ready handshake. MUL and DIV are held for a programmable number of cycles before issue, to cover the ALU's long combinational paths.

## Interface
- `MUL_WAIT`, default 2: extra cycles between MUL/MULC capture and `issue_valid`.
- `DIV_WAIT`, default 8: extra cycles between DIV/DIVC capture and `issue_valid`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: upstream instruction valid.
- `instr` in 32: instruction word.
- `instr_ready` out 1: block accepts `instr` this cycle.
- `ra_addr` out 5: register-file read address A, combinational from `instr[20:16]`.
- `rb_addr` out 5: register-file read address B, combinational from `instr[15:11]`.
- `ra_data`, `rb_data` in 32: register-file read data, valid in the same cycle.
- `issue_valid` out 1: downstream bundle valid.
- `issue_ready` in 1: downstream consumes the bundle.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_fn` out 6: ALU function code.
- `rc` out 5: destination register.
- `illegal` out 1: one-cycle pulse on acceptance of an unsupported opcode.

## Operation
- Field layout: opcode = `instr[31:26]`, rc = `[25:21]`, ra = `[20:16]`, rb = `[15:11]`, literal = `[15:0]`.
- Opcode map (the C variant adds 0x10):
  - 0x20 ADD, 0x21 SUB, 0x22 MUL, 0x23 DIV
  - 0x24 CMPEQ, 0x25 CMPLT, 0x26 CMPLE
  - 0x28 AND, 0x29 OR, 0x2A XOR, 0x2B XNOR
  - 0x2C SHL, 0x2D SHR, 0x2E SRA
  - Each maps to the matching `alu_*` constant.
  - 0x27, 0x2F, 0x37, 0x3F and all opcodes outside 0x20–0x3F are illegal.
- Operand A: `ra_data`, forced to 0 when ra = 31.
- Operand B:
  - Register form (opcode[4]=0): `rb_data`, forced to 0 when rb = 31.
  - Literal form (opcode[4]=1): literal sign-extended to 32 bits. The rb field is ignored.
- Acceptance is `instr_valid && instr_ready` at a rising edge. Operands, fn and rc are registered at that edge.
- States: IDLE, WAIT, VALID.
  - IDLE: `instr_ready`=1.
    - Accept legal non-MUL/DIV → VALID.
    - Accept MUL/DIV with wait > 0 → WAIT, counter loaded with the wait value. With wait = 0 → VALID.
    - Accept illegal → stay IDLE and pulse `illegal`.
  - WAIT: `instr_ready`=0. The counter decrements each cycle. When the counter = 1 → VALID.
  - VALID: `issue_valid`=1; `instr_ready` = `issue_ready`.
    - Handshake with no new acceptance → IDLE.
    - Handshake with a simultaneous acceptance → transitions as from IDLE. This gives back-to-back issue with no bubble.
    - No handshake → hold. The bundle stays stable.
- Counter width: `$clog2(max(MUL_WAIT, DIV_WAIT)+1)`, minimum 1 bit.

## Timing
- Reset (asynchronous, on `reset_n` low) values:
  - State IDLE, counter 0.
  - `issue_valid`=0, `illegal`=0.
  - `alu_a`=0, `alu_b`=0, `alu_fn`=0, `rc`=0.
  - `instr_ready`=1 immediately after reset release.
- Simple-op latency: `issue_valid` rises 1 cycle after the acceptance edge.
- MUL/DIV latency: `issue_valid` rises 1 + `MUL_WAIT` (or 1 + `DIV_WAIT`) cycles after acceptance.
- `illegal` is high for exactly the one cycle after the acceptance edge. No bundle is issued for that instruction.
- While `issue_valid`=1 and `issue_ready`=0:
  - `alu_a`, `alu_b`, `alu_fn` and `rc` are held stable.
  - `ra_data` and `rb_data` are ignored.
- Reset asserted during WAIT or VALID: the pending instruction is discarded and never issued.
- Throughput: one instruction per cycle for non-MUL/DIV ops when `issue_ready` is held at 1.

## Test plan
- ADD: `instr`=0x80611000 (rc=3, ra=1, rb=2), `ra_data`=5, `rb_data`=7 → next cycle `issue_valid`=1, a=5, b=7, fn=`alu_ADD`, rc=3.
- ADDC literal: `instr`=0xC041FFFC, `ra_data`=10 → a=10, b=0xFFFFFFFC, fn=`alu_ADD`, rc=2.
- R31 and literal forms:
  - ra=31, `ra_data`=0xDEADBEEF → a=0.
  - CMPLEC with literal 0x7FFF → b=0x00007FFF.
- DIV with `DIV_WAIT`=8 and `issue_ready`=1:
  - `issue_valid` rises exactly 9 cycles after acceptance.
  - `instr_ready` is 0 for the 8 WAIT cycles.
  - An ADD presented behind the DIV issues only after the DIV issues.
- Backpressure and streaming:
  - Hold `issue_ready`=0 for 5 cycles with a stream of ADDs → bundle stable, `instr_ready`=0.
  - Release → one issue per cycle, in order, no loss or duplication.
- Illegal and reset:
  - Opcode 0x27 → `illegal` pulses 1 cycle and no `issue_valid`.
  - `reset_n` low mid-WAIT on a MUL → all outputs return to reset values and no issue follows.
